// File: rtl/core_pkg.sv
// Shared types and default constants for the fetch sequencer of the monocycle core.
package core_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    localparam addr_t RESET_PC_DEF = 32'h0000_4000;
    localparam addr_t TRAP_VEC_DEF = 32'h0000_0080;
    localparam addr_t PC_STEP_DEF  = 32'd4;

    // Instruction addresses are word aligned; the two low bits are never loaded into pc.
    function automatic addr_t align_word(input addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: trap vector beats jump, jump beats branch, branch beats sequential flow.
module pc_next_mux
    import core_pkg::*;
#(
    parameter addr_t TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        trap,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_inc,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_inc;
        if (trap) begin
            next_pc = TRAP_VEC;
        end else if (jump) begin
            next_pc = align_word(jump_target);
        end else if (branch_taken) begin
            next_pc = align_word(branch_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer: BOOT -> FETCH -> ISSUE loop, HALTED sink.
module pc_sequencer
    import core_pkg::*;
#(
    parameter addr_t RESET_PC     = RESET_PC_DEF,
    parameter addr_t TRAP_VEC     = TRAP_VEC_DEF,
    parameter addr_t PC_STEP      = PC_STEP_DEF,
    parameter addr_t RETIRED_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_inc,
    output logic        instr_valid,
    output logic [31:0] retired_count,
    output logic        halted
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;
    logic [31:0] pc_inc_w;

    assign pc_inc_w = pc_q + PC_STEP;

    pc_next_mux #(
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_next_mux (
        .trap          (trap),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_inc        (pc_inc_w),
        .next_pc       (next_pc)
    );

    // Redirects only matter when an issued instruction actually leaves ISSUE.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            retired_q <= RETIRED_INIT;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req      = (state_q == FETCH);
    assign instr_valid   = (state_q == ISSUE);
    assign halted        = (state_q == HALTED);
    assign pc            = pc_q;
    assign pc_inc        = pc_inc_w;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: cycle-level reference model plus directed scenarios with literal expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        instr_valid;
    logic [31:0] retired_count;
    logic        halted;

    logic        w_reset = 1'b1;
    logic        w_ready = 1'b1;
    logic        w_imem_req;
    logic [31:0] w_pc;
    logic [31:0] w_pc_inc;
    logic        w_instr_valid;
    logic [31:0] w_retired;
    logic        w_halted;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .halt          (halt),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_inc        (pc_inc),
        .instr_valid   (instr_valid),
        .retired_count (retired_count),
        .halted        (halted)
    );

    // Second instance starts at the top of the address space with a saturated counter to exercise wrap.
    pc_sequencer #(
        .RESET_PC     (32'hFFFF_FFFC),
        .RETIRED_INIT (32'hFFFF_FFFF)
    ) dut_wrap (
        .clk           (clk),
        .reset         (w_reset),
        .imem_ready    (w_ready),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .trap          (1'b0),
        .halt          (1'b0),
        .imem_req      (w_imem_req),
        .pc            (w_pc),
        .pc_inc        (w_pc_inc),
        .instr_valid   (w_instr_valid),
        .retired_count (w_retired),
        .halted        (w_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the fetch port and datapath should observe, one step per clock.
    logic        m_init = 1'b0;
    logic        m_boot, m_req, m_val, m_halt;
    logic [31:0] m_pc, m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_boot = 1'b1; m_req = 1'b0; m_val = 1'b0; m_halt = 1'b0;
            m_pc = 32'h0000_4000; m_cnt = 32'h0;
        end else if (m_init) begin
            if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1;
            end else if (m_req) begin
                if (imem_ready) begin m_req = 1'b0; m_val = 1'b1; end
            end else if (m_val && !stall) begin
                if (trap)              m_pc = 32'h0000_0080;
                else if (jump)         m_pc = jump_target & 32'hFFFF_FFFC;
                else if (branch_taken) m_pc = branch_target & 32'hFFFF_FFFC;
                else                   m_pc = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
                m_val = 1'b0;
                if (halt) m_halt = 1'b1; else m_req = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_imem_req", {31'b0, imem_req}, {31'b0, m_req});
            chk("model_instr_valid", {31'b0, instr_valid}, {31'b0, m_val});
            chk("model_halted", {31'b0, halted}, {31'b0, m_halt});
            chk("model_pc", pc, m_pc);
            chk("model_pc_inc", pc_inc, m_pc + 32'd4);
            chk("model_retired", retired_count, m_cnt);
        end
    end

    task automatic wait_issue(input string name);
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_valid) begin
            failures++;
            $display("FAIL %s: no instr_valid within 20 cycles (got 0 expected 1)", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_reset_pc_inc", w_pc_inc, 32'h0);
        chk("wrap_reset_count", w_retired, 32'hFFFF_FFFF);
        w_reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_next_pc", w_pc, 32'h0);
        chk("wrap_count", w_retired, 32'h0);
        chk("wrap_fetch_again", {31'b0, w_imem_req}, 32'd1);
    end

    initial begin
        logic [31:0] c0;
        int req_n, val_n;

        // Reset state, then straight-line flow with memory always ready.
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);
        chk("reset_pc", pc, 32'h0000_4000);
        chk("reset_count", retired_count, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_issue("seq_issue");
            chk("seq_pc", pc, 32'h0000_4000 + 32'(4 * k));
        end
        @(negedge clk);
        chk("seq_count3", retired_count, 32'd3);
        chk("seq_valid_low", {31'b0, instr_valid}, 32'd0);

        // Memory not ready for three FETCH cycles.
        imem_ready = 1'b0;
        do_reset();
        req_n = 0; val_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i <= 5 && imem_req) begin
                req_n++;
                chk("wait_pc_held", pc, 32'h0000_4000);
            end
            if (instr_valid) val_n++;
            imem_ready = (i == 4);
            @(negedge clk);
        end
        chk("wait_req_cycles", 32'(req_n), 32'd4);
        chk("wait_valid_pulses", 32'(val_n), 32'd1);

        // Two stall cycles at pc=4004; a branch offered during stall must be ignored.
        imem_ready = 1'b1;
        wait_issue("stall_issue");
        chk("stall_pc0", pc, 32'h0000_4004);
        c0 = retired_count;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_9000;
        @(negedge clk);
        chk("stall_valid1", {31'b0, instr_valid}, 32'd1);
        chk("stall_pc1", pc, 32'h0000_4004);
        @(negedge clk);
        chk("stall_valid2", {31'b0, instr_valid}, 32'd1);
        chk("stall_count", retired_count, c0);
        stall = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        chk("stall_exit_pc", pc, 32'h0000_4008);
        chk("stall_exit_count", retired_count, c0 + 32'd1);

        // All redirects together: trap wins, then jump wins over branch with low bits cleared.
        wait_issue("prio_issue1");
        trap = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 32'h0000_5003; branch_target = 32'h0000_7000;
        @(negedge clk);
        chk("prio_trap_pc", pc, 32'h0000_0080);
        trap = 1'b0;
        wait_issue("prio_issue2");
        @(negedge clk);
        chk("prio_jump_pc", pc, 32'h0000_5000);
        jump = 1'b0;
        wait_issue("prio_issue3");
        @(negedge clk);
        chk("prio_branch_pc", pc, 32'h0000_7000);
        branch_taken = 1'b0;

        // Top of address space wraps to zero.
        wait_issue("top_issue");
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_pc_inc", pc_inc, 32'h0);
        jump = 1'b0;
        wait_issue("top_issue2");
        @(negedge clk);
        chk("top_wrap_pc", pc, 32'h0);

        // Halt together with a taken branch.
        wait_issue("halt_issue");
        halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_6000;
        @(negedge clk);
        chk("halt_pc", pc, 32'h0000_6000);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_req", {31'b0, imem_req}, 32'd0);
        halt = 1'b0; branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_frozen_pc", pc, 32'h0000_6000);
        chk("halt_stays", {31'b0, halted}, 32'd1);

        // Reset while a fetch is pending.
        imem_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("midfetch_req_before", {31'b0, imem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midfetch_req", {31'b0, imem_req}, 32'd0);
        chk("midfetch_pc", pc, 32'h0000_4000);
        chk("midfetch_halted", {31'b0, halted}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midfetch_refetch", {31'b0, imem_req}, 32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
